cc_frame_scheduler: RTL
=======================

// Module: cc_frame_scheduler
// PURPOSE
//  Sequences one analysis frame per FRAME_DIV DFT sample reads: delayed NoteFinder start -> LinearVisualizer
//  start -> LED driver start. Replaces the free-running 4-tap delay line and direct start wiring in the top.
//  Also owns the LED driver: it never restarts mid-frame. Frames are dropped and counted when stages are busy.
//  A watchdog recovers from a stalled stage.
// PARAMETERS
//  READ_DELAY  4      cycles from qualifying sampleRead to nfStart; legal range >=1
//  FRAME_DIV   1      sampleRead pulses per analysis frame; legal range >=1
//  TIMEOUT     65535  max cycles in S_NF_RUN or S_LV_RUN before abort
//  CNT_W       8      width of saturating drop/skip counters
// PORTS
//  clk          in   1      system clock
//  rst          in   1      asynchronous, active-low reset
//  enable       in   1      1 = arm new frames; 0 = finish in-flight work, arm nothing new
//  sampleRead   in   1      1-cycle pulse from DFT doingRead
//  nfFinished   in   1      1-cycle pulse, NoteFinder done
//  lvValid      in   1      1-cycle pulse, LinearVisualizer data_v (rgb/LEDCounts valid)
//  ledDone      in   1      1-cycle pulse, LED driver frame complete
//  nfStart      out  1      1-cycle pulse, NoteFinder startCycle
//  lvStart      out  1      1-cycle pulse, LinearVisualizer start
//  ledStart     out  1      1-cycle pulse, LED driver start
//  busy         out  1      FSM not in S_IDLE or LED tracker busy
//  state        out  2      current FSM state (debug)
//  nfSkipped    out  CNT_W  frames not started because FSM was busy (saturating)
//  ledDropped   out  CNT_W  LV results overwritten before LED output (saturating)
//  timeoutErr   out  1      sticky; set on watchdog abort
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0; state=S_IDLE; all counters 0; pending=0; ledBusy=0.
//  All outputs are registered. Pulse inputs are sampled on posedge clk. Every output pulse lasts exactly 1 cycle.
//  Sample counter: increments on sampleRead while enable=1.
//   The pulse that brings it to FRAME_DIV is the frame pulse; the counter returns to 0.
//   enable=0 clears the counter.
//  Frame pulse at cycle t:
//   - If state=S_IDLE: go to S_DELAY and load delay counter.
//   - Otherwise: nfSkipped += 1 (saturating) and state is unchanged.
//  FSM:
//   S_IDLE   -> S_DELAY on frame pulse.
//   S_DELAY  -> S_NF_RUN when delay expires; nfStart=1 in cycle t+READ_DELAY (READ_DELAY=4 matches legacy timing).
//   S_NF_RUN -> S_LV_RUN on nfFinished; lvStart=1 in the next cycle.
//   S_LV_RUN -> S_IDLE on lvValid; LED handoff event raised in the same cycle.
//  Watchdog:
//   - Cycle counter clears on entry to S_NF_RUN and on entry to S_LV_RUN.
//   - Reaching TIMEOUT in either state: timeoutErr<=1, state<=S_IDLE, no further start pulses for that frame.
//  Stray nfFinished/lvValid outside their wait state: ignored, no state change.
//  LED tracker (ledBusy, pending), on handoff event H and ledDone D:
//   - H & !ledBusy:             ledStart next cycle; ledBusy<=1.
//   - H & ledBusy & !pending:   pending<=1.
//   - H & ledBusy & pending:    ledDropped += 1 (saturating); pending stays 1.
//   - D & pending (no H):       ledStart next cycle; pending<=0; ledBusy stays 1.
//   - D & !pending (no H):      ledBusy<=0.
//   - H & D, same cycle:        ledStart next cycle; pending<=0; ledBusy stays 1. If pending was 1,
//                               ledDropped += 1 (saturating).
//  enable deasserted mid-frame: the current frame completes normally, including LED output. timeoutErr is not cleared.
//  Counters saturate at all-ones and never wrap.
// STRUCTURE
//  CCHW package: typedef enum logic [1:0] {S_IDLE, S_DELAY, S_NF_RUN, S_LV_RUN} sched_state_t.
//  Sub-module cc_led_handoff: LED tracker (ledBusy/pending/ledDropped).
//   Ports: clk, rst, handoff, ledDone, ledStart, ledBusy, ledDropped.
//  The parent contains the sample counter, delay counter, watchdog and FSM.
// TESTING
//  T1 Basic frame (FRAME_DIV=1): sampleRead at cycle 10 -> nfStart at 14. nfFinished at 40 -> lvStart at 41.
//     lvValid at 60 -> ledStart at 61. busy drops after ledDone.
//  T2 FRAME_DIV=3: sampleRead pulses at cycles 10, 20, 30 -> only one nfStart, at 34.
//  T3 Frame pulse while in S_NF_RUN -> no nfStart, nfSkipped=1. 256 such pulses with CNT_W=8 -> nfSkipped=255.
//  T4 LED busy: lvValid x3 before ledDone -> ledDropped=1. ledDone -> one ledStart next cycle.
//     Second ledDone -> ledBusy=0. Also: ledDone and lvValid in the same cycle -> ledStart next cycle.
//  T5 TIMEOUT=100, nfFinished withheld -> timeoutErr=1 at 100 cycles after nfStart, state=S_IDLE.
//     Next frame pulse -> normal nfStart.
//  T6 rst low during S_LV_RUN with ledBusy=1 -> all outputs 0 immediately (async). After release, T1 passes again.

Source files
------------

// File: rtl/cc_frame_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cc_frame_scheduler_pkg
//  Description : Shared types for the analysis-frame scheduler. Holds the
//                scheduler FSM state encoding and its width.
//  Revision    : 1.0  initial release
// ============================================================================
package cc_frame_scheduler_pkg;

    localparam int c_STATE_W = 2;

    // Scheduler FSM states.
    //   S_IDLE   : waiting for a frame pulse
    //   S_DELAY  : counting down before NoteFinder start
    //   S_NF_RUN : NoteFinder running, waiting for nfFinished
    //   S_LV_RUN : LinearVisualizer running, waiting for lvValid
    typedef enum logic [c_STATE_W-1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_NF_RUN = 2'd2,
        S_LV_RUN = 2'd3
    } sched_state_t;

endpackage : cc_frame_scheduler_pkg
`default_nettype wire

// File: rtl/cc_frame_scheduler_led_handoff.sv
`default_nettype none
// ============================================================================
//  Module      : cc_led_handoff
//  Description : LED driver start tracker. Accepts a handoff event each time
//                a LinearVisualizer result becomes valid and starts the LED
//                driver without ever restarting it mid-frame. At most one
//                result is held back while the driver is busy; any further
//                result overwrites the held one and is counted as dropped.
//  Ports       : clk        in   system clock
//                rst        in   asynchronous active-low reset
//                handoff    in   1-cycle pulse, new LV result available
//                ledDone    in   1-cycle pulse, LED driver frame complete
//                ledStart   out  1-cycle pulse, LED driver start (registered)
//                ledBusy    out  LED driver currently owns a frame
//                ledDropped out  saturating count of overwritten results
//  Revision    : 1.0  initial release
// ============================================================================
module cc_led_handoff #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             handoff,
    input  logic             ledDone,
    output logic             ledStart,
    output logic             ledBusy,
    output logic [CNT_W-1:0] ledDropped
);

    logic             r_busy;
    logic             r_pending;
    logic             r_start;
    logic [CNT_W-1:0] r_dropped;

    logic             w_busy_nxt;
    logic             w_pending_nxt;
    logic             w_start_nxt;
    logic             w_drop;

    always_comb begin
        w_busy_nxt    = r_busy;
        w_pending_nxt = r_pending;
        w_start_nxt   = 1'b0;
        w_drop        = 1'b0;

        if (handoff && ledDone) begin
            // The driver finishes as a new result arrives: start it straight
            // away on the newest result. A held result is superseded.
            w_start_nxt   = 1'b1;
            w_busy_nxt    = 1'b1;
            w_pending_nxt = 1'b0;
            w_drop        = r_pending;
        end else if (handoff) begin
            if (!r_busy) begin
                w_start_nxt = 1'b1;
                w_busy_nxt  = 1'b1;
            end else if (!r_pending) begin
                w_pending_nxt = 1'b1;
            end else begin
                // Held result replaced by the newer one.
                w_drop = 1'b1;
            end
        end else if (ledDone) begin
            if (r_pending) begin
                w_start_nxt   = 1'b1;
                w_pending_nxt = 1'b0;
            end else begin
                w_busy_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy    <= 1'b0;
            r_pending <= 1'b0;
            r_start   <= 1'b0;
            r_dropped <= '0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_pending <= w_pending_nxt;
            r_start   <= w_start_nxt;
            if (w_drop && (r_dropped != '1)) begin
                r_dropped <= r_dropped + 1'b1;
            end
        end
    end

    assign ledStart   = r_start;
    assign ledBusy    = r_busy;
    assign ledDropped = r_dropped;

endmodule : cc_led_handoff
`default_nettype wire

// File: rtl/cc_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : cc_frame_scheduler
//  Description : Sequences one analysis frame per FRAME_DIV DFT sample reads:
//                delayed NoteFinder start -> LinearVisualizer start -> LED
//                driver start. Frames arriving while the pipeline is busy are
//                dropped and counted. A watchdog aborts a frame whose stage
//                stalls for TIMEOUT cycles.
//  Parameters  : READ_DELAY  cycles from frame pulse to nfStart (>=1)
//                FRAME_DIV   sampleRead pulses per frame (>=1)
//                TIMEOUT     max cycles in S_NF_RUN / S_LV_RUN (>=1)
//                CNT_W       width of saturating drop/skip counters
//  Ports       : clk         in   system clock
//                rst         in   asynchronous active-low reset
//                enable      in   1 = arm new frames, 0 = drain only
//                sampleRead  in   1-cycle pulse from DFT read
//                nfFinished  in   1-cycle pulse, NoteFinder done
//                lvValid     in   1-cycle pulse, LinearVisualizer valid
//                ledDone     in   1-cycle pulse, LED driver frame complete
//                nfStart     out  1-cycle pulse, NoteFinder start
//                lvStart     out  1-cycle pulse, LinearVisualizer start
//                ledStart    out  1-cycle pulse, LED driver start
//                busy        out  FSM not idle or LED driver busy
//                state       out  current FSM state (debug)
//                nfSkipped   out  frames not started, saturating
//                ledDropped  out  LV results overwritten, saturating
//                timeoutErr  out  sticky watchdog abort flag
//  Revision    : 1.0  initial release
// ============================================================================
module cc_frame_scheduler
    import cc_frame_scheduler_pkg::*;
#(
    parameter int READ_DELAY = 4,
    parameter int FRAME_DIV  = 1,
    parameter int TIMEOUT    = 65535,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 sampleRead,
    input  logic                 nfFinished,
    input  logic                 lvValid,
    input  logic                 ledDone,
    output logic                 nfStart,
    output logic                 lvStart,
    output logic                 ledStart,
    output logic                 busy,
    output logic [c_STATE_W-1:0] state,
    output logic [CNT_W-1:0]     nfSkipped,
    output logic [CNT_W-1:0]     ledDropped,
    output logic                 timeoutErr
);

    // ------------------------------------------------------------------
    // Counter sizing. The delay counter is loaded with READ_DELAY-2 because
    // entering S_DELAY and issuing the registered nfStart each take a cycle.
    // The watchdog counts 0..TIMEOUT-1 and aborts on the last value, so the
    // abort is visible exactly TIMEOUT cycles after entering the run state.
    // ------------------------------------------------------------------
    localparam int c_SCNT_W = (FRAME_DIV > 1)  ? $clog2(FRAME_DIV)      : 1;
    localparam int c_DLY_W  = (READ_DELAY > 2) ? $clog2(READ_DELAY - 1) : 1;
    localparam int c_WD_W   = (TIMEOUT > 1)    ? $clog2(TIMEOUT)        : 1;

    localparam logic [c_SCNT_W-1:0] c_SCNT_LAST = c_SCNT_W'(FRAME_DIV - 1);
    localparam logic [c_DLY_W-1:0]  c_DLY_LOAD  =
        c_DLY_W'((READ_DELAY > 2) ? (READ_DELAY - 2) : 0);
    localparam logic [c_WD_W-1:0]   c_WD_LAST   = c_WD_W'(TIMEOUT - 1);

    // With a one-cycle delay there is no room for S_DELAY: the frame pulse
    // itself must launch nfStart.
    localparam bit c_DIRECT_START = (READ_DELAY == 1);

    // ------------------------------------------------------------------
    // Reset: asserted asynchronously, released on a clock edge through two
    // flops so every downstream flop leaves reset in the same cycle.
    // ------------------------------------------------------------------
    logic r_rst_meta;
    logic r_rst_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    // ------------------------------------------------------------------
    // Sample counter: the FRAME_DIV-th qualifying sampleRead is the frame
    // pulse. Dropping enable discards a partial count.
    // ------------------------------------------------------------------
    logic [c_SCNT_W-1:0] r_scnt;
    logic                w_frame;

    assign w_frame = enable && sampleRead && (r_scnt == c_SCNT_LAST);

    always_ff @(posedge clk or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_scnt <= '0;
        end else if (!enable) begin
            r_scnt <= '0;
        end else if (sampleRead) begin
            r_scnt <= w_frame ? '0 : (r_scnt + 1'b1);
        end
    end

    // ------------------------------------------------------------------
    // Scheduler FSM
    // ------------------------------------------------------------------
    sched_state_t        r_state;
    sched_state_t        w_state_nxt;
    logic [c_DLY_W-1:0]  r_dly;
    logic [c_DLY_W-1:0]  w_dly_nxt;
    logic [c_WD_W-1:0]   r_wd;
    logic [c_WD_W-1:0]   w_wd_nxt;
    logic                r_nf_start;
    logic                w_nf_start_nxt;
    logic                r_lv_start;
    logic                w_lv_start_nxt;
    logic                r_timeout_err;
    logic                w_timeout_nxt;
    logic                w_handoff;
    logic                w_skip;
    logic [CNT_W-1:0]    r_nf_skipped;

    // A frame pulse that finds the FSM anywhere but idle is lost.
    assign w_skip = w_frame && (r_state != S_IDLE);

    always_ff @(posedge clk or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_dly_nxt      = r_dly;
        // Watchdog idles at zero, so every entry into a run state starts
        // from a cleared count.
        w_wd_nxt       = '0;
        w_nf_start_nxt = 1'b0;
        w_lv_start_nxt = 1'b0;
        w_timeout_nxt  = r_timeout_err;
        w_handoff      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_frame) begin
                    if (c_DIRECT_START) begin
                        w_state_nxt    = S_NF_RUN;
                        w_nf_start_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_DELAY;
                        w_dly_nxt   = c_DLY_LOAD;
                    end
                end
            end

            S_DELAY: begin
                if (r_dly == '0) begin
                    w_state_nxt    = S_NF_RUN;
                    w_nf_start_nxt = 1'b1;
                end else begin
                    w_dly_nxt = r_dly - 1'b1;
                end
            end

            S_NF_RUN: begin
                // A finish arriving on the last watchdog cycle still counts.
                if (nfFinished) begin
                    w_state_nxt    = S_LV_RUN;
                    w_lv_start_nxt = 1'b1;
                end else if (r_wd == c_WD_LAST) begin
                    w_state_nxt   = S_IDLE;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                end
            end

            S_LV_RUN: begin
                if (lvValid) begin
                    w_state_nxt = S_IDLE;
                    w_handoff   = 1'b1;
                end else if (r_wd == c_WD_LAST) begin
                    w_state_nxt   = S_IDLE;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_dly         <= '0;
            r_wd          <= '0;
            r_nf_start    <= 1'b0;
            r_lv_start    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_nf_skipped  <= '0;
        end else begin
            r_dly         <= w_dly_nxt;
            r_wd          <= w_wd_nxt;
            r_nf_start    <= w_nf_start_nxt;
            r_lv_start    <= w_lv_start_nxt;
            r_timeout_err <= w_timeout_nxt;
            if (w_skip && (r_nf_skipped != '1)) begin
                r_nf_skipped <= r_nf_skipped + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // LED driver ownership
    // ------------------------------------------------------------------
    logic w_led_busy;

    cc_led_handoff #(
        .CNT_W (CNT_W)
    ) u_led_handoff (
        .clk        (clk),
        .rst        (r_rst_sync),
        .handoff    (w_handoff),
        .ledDone    (ledDone),
        .ledStart   (ledStart),
        .ledBusy    (w_led_busy),
        .ledDropped (ledDropped)
    );

    // ------------------------------------------------------------------
    // Outputs. busy is decoded purely from flops, so it carries no
    // combinational path from any input.
    // ------------------------------------------------------------------
    assign nfStart    = r_nf_start;
    assign lvStart    = r_lv_start;
    assign busy       = (r_state != S_IDLE) || w_led_busy;
    assign state      = r_state;
    assign nfSkipped  = r_nf_skipped;
    assign timeoutErr = r_timeout_err;

endmodule : cc_frame_scheduler
`default_nettype wire
